// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO controller: binary/gray write and read pointer pairs around an
// external 2**ASIZE-entry dual-port RAM, with registered full/empty/level/threshold flags.
module gray_fifo_ctrl #(
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic             clr_err,
    output logic             wen,
    output logic             ren,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   wptr_gray,
    output logic [ASIZE:0]   rptr_gray,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   level,
    output logic             ovf,
    output logic             udf
);

    localparam logic [ASIZE:0] AF_L = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_L = (ASIZE+1)'(AE_LEVEL);

    logic [ASIZE:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [ASIZE:0] rbin_q, rbin_d, rgray_q, rgray_d;
    logic [ASIZE:0] level_q, level_d;
    logic           full_q, full_d, empty_q, empty_d;
    logic           af_q, af_d, ae_q, ae_d;
    logic           ovf_q, ovf_d, udf_q, udf_d;

    // Requests are gated by the registered flags, so a full FIFO rejects a write
    // even when a read is accepted on the same edge (no fall-through either way).
    assign wen = wr_req & ~full_q;
    assign ren = rd_req & ~empty_q;

    always_comb begin
        wbin_d  = wbin_q + {{ASIZE{1'b0}}, wen};
        rbin_d  = rbin_q + {{ASIZE{1'b0}}, ren};
        wgray_d = (wbin_d >> 1) ^ wbin_d;
        rgray_d = (rbin_d >> 1) ^ rbin_d;
        empty_d = (wgray_d == rgray_d);
        // Full when the pointers differ by exactly one lap: top two gray bits inverted.
        full_d  = (wgray_d == {~rgray_d[ASIZE:ASIZE-1], rgray_d[ASIZE-2:0]});
        level_d = wbin_d - rbin_d;
        af_d    = (level_d >= AF_L);
        ae_d    = (level_d <= AE_L);
        ovf_d   = (wr_req & full_q) | (ovf_q & ~clr_err);
        udf_d   = (rd_req & empty_q) | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rbin_q  <= '0;
            rgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign waddr        = wbin_q[ASIZE-1:0];
    assign raddr        = rbin_q[ASIZE-1:0];
    assign wptr_gray    = wgray_q;
    assign rptr_gray    = rgray_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign level        = level_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Bench for gray_fifo_ctrl: directed scenarios plus random traffic, checked every
// cycle against an occupancy-count reference model.
module tb_gray_fifo_ctrl;

    localparam int ASIZE = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_req = 1'b0, rd_req = 1'b0, clr_err = 1'b0;
    logic             wen, ren, full, empty, almost_full, almost_empty, ovf, udf;
    logic [ASIZE-1:0] waddr, raddr;
    logic [ASIZE:0]   wptr_gray, rptr_gray, level;

    gray_fifo_ctrl #(.ASIZE(ASIZE), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .clr_err(clr_err),
        .wen(wen), .ren(ren), .waddr(waddr), .raddr(raddr),
        .wptr_gray(wptr_gray), .rptr_gray(rptr_gray), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nbad = 0;

    // reference model: occupancy count and total transfers per side
    int  cnt, wtot, rtot;
    bit  movf, mudf;
    logic [ASIZE:0] prev_wg, prev_rg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_gray(input int n);
        int b;
        b = n % (2*DEPTH);
        return 32'(b ^ (b / 2));
    endfunction

    task automatic model_reset();
        cnt = 0; wtot = 0; rtot = 0; movf = 0; mudf = 0;
        prev_wg = '0; prev_rg = '0;
    endtask

    task automatic check_regs(input string pfx);
        chk({pfx, ".level"}, 32'(level), 32'(cnt));
        chk({pfx, ".full"}, 32'(full), 32'(cnt == DEPTH));
        chk({pfx, ".empty"}, 32'(empty), 32'(cnt == 0));
        chk({pfx, ".afull"}, 32'(almost_full), 32'(cnt >= AFL));
        chk({pfx, ".aempty"}, 32'(almost_empty), 32'(cnt <= AEL));
        chk({pfx, ".wgray"}, 32'(wptr_gray), to_gray(wtot));
        chk({pfx, ".rgray"}, 32'(rptr_gray), to_gray(rtot));
        chk({pfx, ".ovf"}, 32'(ovf), 32'(movf));
        chk({pfx, ".udf"}, 32'(udf), 32'(mudf));
    endtask

    // One clock: drive at negedge, check combinational outputs, step model at
    // posedge, then check registered outputs just after the edge.
    task automatic cycle(input string pfx, input bit w, input bit r, input bit c);
        bit wacc, racc;
        @(negedge clk);
        wr_req = w; rd_req = r; clr_err = c;
        #1;
        wacc = w && (cnt < DEPTH);
        racc = r && (cnt > 0);
        chk({pfx, ".wen"}, 32'(wen), 32'(wacc));
        chk({pfx, ".ren"}, 32'(ren), 32'(racc));
        chk({pfx, ".waddr"}, 32'(waddr), 32'(wtot % DEPTH));
        chk({pfx, ".raddr"}, 32'(raddr), 32'(rtot % DEPTH));
        @(posedge clk);
        movf = (w && cnt == DEPTH) || (movf && !c);
        mudf = (r && cnt == 0) || (mudf && !c);
        cnt  = cnt + int'(wacc) - int'(racc);
        wtot = wtot + int'(wacc);
        rtot = rtot + int'(racc);
        #1;
        check_regs(pfx);
        if (wacc) chk({pfx, ".wgray1bit"}, 32'($countones(prev_wg ^ wptr_gray)), 32'd1);
        else      chk({pfx, ".wgrayhold"}, 32'(wptr_gray), 32'(prev_wg));
        if (racc) chk({pfx, ".rgray1bit"}, 32'($countones(prev_rg ^ rptr_gray)), 32'd1);
        else      chk({pfx, ".rgrayhold"}, 32'(rptr_gray), 32'(prev_rg));
        prev_wg = wptr_gray;
        prev_rg = rptr_gray;
    endtask

    initial begin
        int pw, pr;
        model_reset();
        #12;
        check_regs("reset");
        @(negedge clk);
        rst = 1'b1;

        // fill: 16 back-to-back writes
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 0, 0);
        chk("fill.wgray_end", 32'(wptr_gray), 32'h18);
        chk("fill.full_end", 32'(full), 32'd1);

        // write while full -> overflow, then clear
        cycle("ovf", 1, 0, 0);
        cycle("clr", 0, 0, 1);

        // full with both requests: read only, then both
        cycle("fullboth", 1, 1, 0);
        chk("fullboth.level", 32'(level), 32'd15);
        cycle("both", 1, 1, 0);
        chk("both.level", 32'(level), 32'd15);

        // drain, then write/read pairs wrapping the pointers
        for (int i = 0; i < DEPTH; i++) cycle("drain", 0, 1, 0);
        for (int i = 0; i < 40; i++) begin
            cycle("pairw", 1, 0, 0);
            cycle("pairr", 0, 1, 0);
        end
        cycle("udf", 0, 1, 0);
        cycle("udfclr", 0, 0, 1);

        // simultaneous new error and clear: set wins
        cycle("setwins", 0, 1, 1);
        cycle("udfclr2", 0, 0, 1);

        // asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1, 0, 0);
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_regs("midrst");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle("resume", 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle("resume", 0, 1, 0);

        // random traffic with shifting write/read bias
        for (int i = 0; i < 10000; i++) begin
            if (i % 500 == 0) begin
                case ((i / 500) % 3)
                    0: begin pw = 80; pr = 30; end
                    1: begin pw = 30; pr = 80; end
                    default: begin pw = 60; pr = 60; end
                endcase
            end
            cycle("rand", $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                  $urandom_range(0, 99) < 5);
        end

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
